// File: rtl/ram4096_arbiter.sv
// ram4096_arbiter: two-requester round-robin arbiter with a short burst lock,
// sharing one ram4096 port (16-bit data, 12-bit address, 1-cycle registered
// read, write-through). Every accepted access gets a response exactly one
// cycle later.
// Optional feature macro: RAM_ARB_STATS_EN adds per-requester grant counters
// (stats_clr, r0_grants, r1_grants). Without it, arbitration is unchanged.
module ram4096_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // requester 0
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic        r0_we,
    input  logic        r0_lock,
    input  logic [11:0] r0_addr,
    input  logic [15:0] r0_wdata,
    output logic        r0_rvalid,
    output logic [15:0] r0_rdata,
    // requester 1
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic        r1_we,
    input  logic        r1_lock,
    input  logic [11:0] r1_addr,
    input  logic [15:0] r1_wdata,
    output logic        r1_rvalid,
    output logic [15:0] r1_rdata,
    // RAM port
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [11:0] ram_address,
    input  logic [15:0] ram_out
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] r0_grants,
    output logic [15:0] r1_grants
`endif
);

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    localparam logic [CW-1:0] MAX_BURST_C = CW'(MAX_BURST);
    // A burst limit of 1 means every locked access would end its own burst.
    localparam logic          LOCK_EN     = (MAX_BURST > 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prio;
    logic            w_prio_nxt;
    logic [CW-1:0]   r_burst_cnt;
    logic [CW-1:0]   w_burst_nxt;
    logic [CW-1:0]   w_burst_inc;
    logic            r_resp_pend;
    logic            r_resp_owner;

    logic            w_arb0;
    logic            w_arb1;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_owner_xfer;
    logic            w_xfer_lock;

    assign w_burst_inc = r_burst_cnt + CW'(1);

    // State, priority pointer and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prio      <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prio      <= w_prio_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Grant selection and next-state logic.
    always_comb begin
        w_arb0       = 1'b0;
        w_arb1       = 1'b0;
        w_state_nxt  = r_state;
        w_prio_nxt   = r_prio;
        w_burst_nxt  = r_burst_cnt;
        w_owner_xfer = 1'b0;
        w_xfer_lock  = 1'b0;

        // While locked, the non-owner only wins a cycle the owner leaves idle;
        // that idle cycle ends the burst.
        case (r_state)
            ST_IDLE: begin
                if (r0_valid && r1_valid) begin
                    w_arb0 = ~r_prio;
                    w_arb1 = r_prio;
                end else begin
                    w_arb0 = r0_valid;
                    w_arb1 = r1_valid;
                end
            end
            ST_LOCK0: begin
                w_arb0 = r0_valid;
                w_arb1 = ~r0_valid & r1_valid;
            end
            ST_LOCK1: begin
                w_arb1 = r1_valid;
                w_arb0 = ~r1_valid & r0_valid;
            end
            default: begin
                w_arb0 = 1'b0;
                w_arb1 = 1'b0;
            end
        endcase

        w_owner_xfer = ((r_state == ST_LOCK0) && w_arb0) ||
                       ((r_state == ST_LOCK1) && w_arb1);
        w_xfer_lock  = (w_arb0 & r0_lock) | (w_arb1 & r1_lock);

        if (w_owner_xfer) begin
            w_burst_nxt = w_burst_inc;
            if (!w_xfer_lock || (w_burst_inc == MAX_BURST_C)) begin
                w_state_nxt = ST_IDLE;
                w_burst_nxt = '0;
                w_prio_nxt  = w_arb0;
            end
        end else begin
            w_state_nxt = ST_IDLE;
            w_burst_nxt = '0;
            if (r_state == ST_LOCK0) begin
                w_prio_nxt = 1'b1;
            end else if (r_state == ST_LOCK1) begin
                w_prio_nxt = 1'b0;
            end
            if (w_arb0 || w_arb1) begin
                w_prio_nxt = w_arb0;
                if (w_xfer_lock && LOCK_EN) begin
                    w_state_nxt = w_arb0 ? ST_LOCK0 : ST_LOCK1;
                    w_burst_nxt = CW'(1);
                end
            end
        end

        // Reset blanks handshakes immediately, independent of the clock.
        w_gnt0 = w_arb0 & rst_n;
        w_gnt1 = w_arb1 & rst_n;
    end

    assign r0_ready = w_gnt0;
    assign r1_ready = w_gnt1;

    // RAM port mux: winner's request, or all zeros when nobody is granted.
    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        if (w_gnt0) begin
            ram_load    = r0_we;
            ram_address = AW'(r0_addr);
            ram_in      = DW'(r0_wdata);
        end else if (w_gnt1) begin
            ram_load    = r1_we;
            ram_address = AW'(r1_addr);
            ram_in      = DW'(r1_wdata);
        end
    end

    // Response tracking: one pending slot is enough for a 1-cycle RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_pend  <= 1'b0;
            r_resp_owner <= 1'b0;
        end else begin
            r_resp_pend  <= w_gnt0 | w_gnt1;
            r_resp_owner <= w_gnt1;
        end
    end

    assign r0_rvalid = r_resp_pend & ~r_resp_owner;
    assign r1_rvalid = r_resp_pend &  r_resp_owner;
    assign r0_rdata  = r0_rvalid ? ram_out : '0;
    assign r1_rdata  = r1_rvalid ? ram_out : '0;

`ifdef RAM_ARB_STATS_EN
    logic [15:0] r_r0_grants;
    logic [15:0] r_r1_grants;

    // Saturating grant counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r0_grants <= '0;
            r_r1_grants <= '0;
        end else if (stats_clr) begin
            r_r0_grants <= '0;
            r_r1_grants <= '0;
        end else begin
            if (w_gnt0 && (r_r0_grants != 16'hFFFF)) begin
                r_r0_grants <= r_r0_grants + 16'd1;
            end
            if (w_gnt1 && (r_r1_grants != 16'hFFFF)) begin
                r_r1_grants <= r_r1_grants + 16'd1;
            end
        end
    end

    assign r0_grants = r_r0_grants;
    assign r1_grants = r_r1_grants;
`endif

endmodule

// File: tb/tb_ram4096_arbiter.sv
// Bench for ram4096_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model
// (grant rules, memory contents, response queue, grant counters).
module tb_ram4096_arbiter;

    localparam int unsigned MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_valid = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
    logic [11:0] r0_addr = '0;
    logic [15:0] r0_wdata = '0;
    logic        r1_valid = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
    logic [11:0] r1_addr = '0;
    logic [15:0] r1_wdata = '0;
    logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [11:0] ram_address;
    logic [15:0] ram_out = '0;
`ifdef RAM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] r0_grants, r1_grants;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram4096_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_lock(r0_lock),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_lock(r1_lock),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
`ifdef RAM_ARB_STATS_EN
        , .stats_clr(stats_clr), .r0_grants(r0_grants), .r1_grants(r1_grants)
`endif
    );

    // ram4096: registered read, write-through on load.
    logic [15:0] ram_mem [4096] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_load) ram_mem[ram_address] <= ram_in;
        ram_out <= ram_load ? ram_in : ram_mem[ram_address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [4096] = '{default: 16'h0000};
    int          m_prio = 0;      // favoured requester when both ask
    int          m_lock = -1;     // requester holding a burst, -1 none
    int          m_run  = 0;      // grants given in current burst
    bit          m_pend = 0;
    int          m_pown = 0;
    logic [15:0] m_pdata = '0;
    int          m_g0 = 0, m_g1 = 0;
    int          glog[$];         // winner per active cycle (-1 = none)

    int          g;
    logic [1:0]  vld;
    logic [1:0]  lk;
    logic [1:0]  wen;
    logic [11:0] ad [2];
    logic [15:0] wd [2];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_r0_ready", 32'(r0_ready), 0);
            chk("rst_r1_ready", 32'(r1_ready), 0);
            chk("rst_r0_rvalid", 32'(r0_rvalid), 0);
            chk("rst_r1_rvalid", 32'(r1_rvalid), 0);
            chk("rst_ram_load", 32'(ram_load), 0);
            m_prio = 0; m_lock = -1; m_run = 0; m_pend = 0;
`ifdef RAM_ARB_STATS_EN
            chk("rst_r0_grants", 32'(r0_grants), 0);
            chk("rst_r1_grants", 32'(r1_grants), 0);
            m_g0 = 0; m_g1 = 0;
`endif
        end else begin
            // response from last cycle's transfer
            chk("r0_rvalid", 32'(r0_rvalid), 32'(m_pend && m_pown == 0));
            chk("r1_rvalid", 32'(r1_rvalid), 32'(m_pend && m_pown == 1));
            chk("r0_rdata", 32'(r0_rdata), (m_pend && m_pown == 0) ? 32'(m_pdata) : 32'd0);
            chk("r1_rdata", 32'(r1_rdata), (m_pend && m_pown == 1) ? 32'(m_pdata) : 32'd0);
`ifdef RAM_ARB_STATS_EN
            chk("r0_grants", 32'(r0_grants), 32'(m_g0));
            chk("r1_grants", 32'(r1_grants), 32'(m_g1));
`endif
            vld = {r1_valid, r0_valid};
            lk  = {r1_lock, r0_lock};
            wen = {r1_we, r0_we};
            ad[0] = r0_addr; ad[1] = r1_addr;
            wd[0] = r0_wdata; wd[1] = r1_wdata;

            // who must win this cycle
            if (m_lock >= 0)
                g = vld[m_lock] ? m_lock : (vld[1 - m_lock] ? 1 - m_lock : -1);
            else if (vld == 2'b11)
                g = m_prio;
            else
                g = vld[0] ? 0 : (vld[1] ? 1 : -1);

            chk("r0_ready", 32'(r0_ready), 32'(g == 0));
            chk("r1_ready", 32'(r1_ready), 32'(g == 1));
            chk("ram_load", 32'(ram_load), (g >= 0) ? 32'(wen[g]) : 32'd0);
            chk("ram_address", 32'(ram_address), (g >= 0) ? 32'(ad[g]) : 32'd0);
            chk("ram_in", 32'(ram_in), (g >= 0) ? 32'(wd[g]) : 32'd0);
            glog.push_back(g);

            // memory and response
            if (g >= 0) begin
                m_pend  = 1;
                m_pown  = g;
                m_pdata = wen[g] ? wd[g] : m_mem[ad[g]];
                if (wen[g]) m_mem[ad[g]] = wd[g];
            end else begin
                m_pend = 0;
            end

            // burst bookkeeping
            if (m_lock >= 0 && g == m_lock) begin
                m_run++;
                if (!lk[g] || m_run == int'(MAX_BURST)) begin
                    m_lock = -1; m_run = 0; m_prio = 1 - g;
                end
            end else begin
                if (m_lock >= 0) m_prio = 1 - m_lock;
                m_lock = -1; m_run = 0;
                if (g >= 0) begin
                    m_prio = 1 - g;
                    if (lk[g] && MAX_BURST > 1) begin
                        m_lock = g; m_run = 1;
                    end
                end
            end
`ifdef RAM_ARB_STATS_EN
            if (stats_clr) begin
                m_g0 = 0; m_g1 = 0;
            end else begin
                if (g == 0 && m_g0 != 65535) m_g0++;
                if (g == 1 && m_g1 != 65535) m_g1++;
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic idle_all();
        r0_valid = 0; r0_lock = 0; r0_we = 0;
        r1_valid = 0; r1_lock = 0; r1_we = 0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 0;
        step(); step();
        rst_n = 1;
    endtask

    task automatic chk_log(input string nm, input int idx, input int exp);
        if (idx < glog.size()) chk(nm, 32'(glog[idx]), 32'(exp));
        else chk({nm, "_missing"}, 32'(glog.size()), 32'(idx + 1));
    endtask

    task automatic new_req(output logic v, output logic we, output logic lck,
                           output logic [11:0] a, output logic [15:0] d);
        v   = ($urandom_range(0, 9) < 7);
        we  = ($urandom_range(0, 9) < 4);
        lck = $urandom_range(0, 1) == 1;
        a   = 12'($urandom_range(0, 15));
        d   = 16'($urandom);
    endtask

    int  start;
    bit  a0, a1;

    initial begin
        do_reset();

        // write r0 then read same address from r1
        r0_valid = 1; r0_we = 1; r0_addr = 12'h005; r0_wdata = 16'hBEEF;
        step();
        r0_valid = 0; r0_we = 0;
        r1_valid = 1; r1_we = 0; r1_addr = 12'h005;
        sample();
        chk("wr_resp_valid", 32'(r0_rvalid), 1);
        chk("wr_resp_data", 32'(r0_rdata), 32'h0000BEEF);
        step();
        r1_valid = 0;
        sample();
        chk("rd_resp_valid", 32'(r1_rvalid), 1);
        chk("rd_resp_data", 32'(r1_rdata), 32'h0000BEEF);

        // alternation with both valid, no lock
        do_reset();
        start = glog.size();
        r0_valid = 1; r0_addr = 12'h010;
        r1_valid = 1; r1_addr = 12'h011;
        repeat (6) step();
        for (int i = 0; i < 6; i++) chk_log("alternate", start + i, i % 2);

        // r0 burst lock limited to MAX_BURST grants
        do_reset();
        start = glog.size();
        r0_valid = 1; r0_lock = 1; r0_addr = 12'h001;
        r1_valid = 1; r1_lock = 0; r1_addr = 12'h002;
        repeat (6) step();
        for (int i = 0; i < 4; i++) chk_log("burst_r0", start + i, 0);
        chk_log("burst_end_r1", start + 4, 1);
        chk_log("burst_restart_r0", start + 5, 0);

        // lock owner going idle releases the bus the same cycle
        do_reset();
        start = glog.size();
        r0_valid = 1; r0_lock = 1;
        r1_valid = 1; r1_lock = 0;
        step();
        r0_valid = 0;
        step();
        r1_valid = 0; r0_valid = 1; r0_lock = 0;
        r1_valid = 1;
        step();
        idle_all();
        chk_log("lock_take", start, 0);
        chk_log("lock_break_r1", start + 1, 1);
        chk_log("after_break_r0", start + 2, 0);

        // reset right after a read accept drops the response
        do_reset();
        r0_valid = 1; r0_addr = 12'h007;
        step();
        r0_valid = 0;
        rst_n = 0;
        sample();
        chk("dropped_rvalid", 32'(r0_rvalid), 0);
        step();
        rst_n = 1;
        start = glog.size();
        r0_valid = 1; r1_valid = 1;
        step();
        idle_all();
        chk_log("post_reset_prio", start, 0);

`ifdef RAM_ARB_STATS_EN
        do_reset();
        r0_valid = 1; r1_valid = 1;
        repeat (5) step();
        idle_all();
        sample();
        chk("stats_r0", 32'(r0_grants), 3);
        chk("stats_r1", 32'(r1_grants), 2);
        step();
        stats_clr = 1;
        step();
        stats_clr = 0;
        sample();
        chk("stats_clr_r0", 32'(r0_grants), 0);
        chk("stats_clr_r1", 32'(r1_grants), 0);
`endif

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            a0 = r0_valid && r0_ready;
            a1 = r1_valid && r1_ready;
            @(posedge clk); #1;
            if (!rst_n) rst_n = ($urandom_range(0, 1) == 1);
            else if ($urandom_range(0, 399) == 0) rst_n = 0;
`ifdef RAM_ARB_STATS_EN
            stats_clr = ($urandom_range(0, 49) == 0);
`endif
            if (!r0_valid || a0) new_req(r0_valid, r0_we, r0_lock, r0_addr, r0_wdata);
            if (!r1_valid || a1) new_req(r1_valid, r1_we, r1_lock, r1_addr, r1_wdata);
        end
        idle_all();
        rst_n = 1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
